// File: rtl/pipeline_pkg.sv
// Shared decode/execute frame layout: field widths, bit offsets and loc extractors.
// The packed struct and the *_LSB offsets describe the same MSB->LSB layout.
package pipeline_pkg;

  localparam int DATA_W    = 32;
  localparam int REGADDR_W = 5;
  localparam int RSEL_W    = 3;

  localparam int WE_LSB     = 0;
  localparam int WSEL_LSB   = WE_LSB + 1;
  localparam int RSEL_LSB   = WSEL_LSB + REGADDR_W;
  localparam int SUB_LSB    = RSEL_LSB + RSEL_W;
  localparam int UNS_LSB    = SUB_LSB + 1;
  localparam int IMMSEL_LSB = UNS_LSB + 1;
  localparam int IMM_LSB    = IMMSEL_LSB + 1;
  localparam int BLOC_LSB   = IMM_LSB + DATA_W;
  localparam int BOP_LSB    = BLOC_LSB + REGADDR_W;
  localparam int ALOC_LSB   = BOP_LSB + DATA_W;
  localparam int AOP_LSB    = ALOC_LSB + REGADDR_W;
  localparam int FRAME_W    = AOP_LSB + DATA_W;

  typedef struct packed {
    logic [DATA_W-1:0]    aOperand;
    logic [REGADDR_W-1:0] aLoc;
    logic [DATA_W-1:0]    bOperand;
    logic [REGADDR_W-1:0] bLoc;
    logic [DATA_W-1:0]    immediateVal;
    logic                 immediateSelect;
    logic                 unsignedSelect;
    logic                 subtractEnable;
    logic [RSEL_W-1:0]    resultSelect;
    logic [REGADDR_W-1:0] writeSelect;
    logic                 writeEnable;
  } frame_t;

  function automatic logic [REGADDR_W-1:0] getALoc(input logic [FRAME_W-1:0] f);
    return f[ALOC_LSB +: REGADDR_W];
  endfunction

  function automatic logic [REGADDR_W-1:0] getBLoc(input logic [FRAME_W-1:0] f);
    return f[BLOC_LSB +: REGADDR_W];
  endfunction

endpackage

// File: rtl/frame_slot.sv
// One frame storage entry: loads a new frame and forwards writeback data into
// either operand whose source register matches; zero-cycle snoop on the load path.
module frame_slot
  import pipeline_pkg::*;
#(
  parameter int DATA_W    = pipeline_pkg::DATA_W,
  parameter int REGADDR_W = pipeline_pkg::REGADDR_W,
  parameter int RSEL_W    = pipeline_pkg::RSEL_W,
  localparam int FW       = 3*DATA_W + 3*REGADDR_W + RSEL_W + 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [FW-1:0]        loadData,
  input  logic                 keep,
  input  logic                 wbValid,
  input  logic [REGADDR_W-1:0] wbAddr,
  input  logic [DATA_W-1:0]    wbData,
  output logic [FW-1:0]        frame
);

  localparam int BLOC = 4 + REGADDR_W + RSEL_W + DATA_W;
  localparam int BOP  = BLOC + REGADDR_W;
  localparam int ALOC = BOP + DATA_W;
  localparam int AOP  = ALOC + REGADDR_W;

  logic [FW-1:0] nextFrame;
  logic          snoopEn;

  // Only live contents are snooped; a slot leaving this cycle is bypassed downstream.
  assign snoopEn = (load || keep) && wbValid && (wbAddr != '0);

  always_comb begin
    nextFrame = frame;
    if (load) nextFrame = loadData;
    if (snoopEn && (nextFrame[ALOC +: REGADDR_W] == wbAddr)) nextFrame[AOP +: DATA_W] = wbData;
    if (snoopEn && (nextFrame[BLOC +: REGADDR_W] == wbAddr)) nextFrame[BOP +: DATA_W] = wbData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame <= '0;
    else       frame <= nextFrame;
  end

endmodule

// File: rtl/pipeline_frame_buffer.sv
// Elastic DEPTH-entry decode->execute frame buffer with flush and writeback snoop.
// One cycle push-to-head latency; in_ready drops only when every slot is held.
module pipeline_frame_buffer
  import pipeline_pkg::*;
#(
  parameter int DATA_W    = pipeline_pkg::DATA_W,
  parameter int REGADDR_W = pipeline_pkg::REGADDR_W,
  parameter int RSEL_W    = pipeline_pkg::RSEL_W,
  parameter int DEPTH     = 2,
  localparam int FW       = 3*DATA_W + 3*REGADDR_W + RSEL_W + 4,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FW-1:0]        frame_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FW-1:0]        frame_out,
  input  logic                 flush,
  input  logic                 wb_valid,
  input  logic [REGADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]    wb_data,
  output logic [CNT_W-1:0]     occupancy
);

  logic [PTR_W-1:0] wp, rp;
  logic [CNT_W-1:0] count;
  logic             push, pop;
  logic [DEPTH-1:0] slotLoad, slotKeep;
  logic [FW-1:0]    slotData [DEPTH];

  assign in_ready  = !reset && (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign occupancy = count;
  assign frame_out = slotData[rp];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + PTR_W'(push);
      rp    <= rp + PTR_W'(pop);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : gSlot
    logic [PTR_W-1:0] rel;
    // Slot i is held when its distance from the head is below the count.
    assign rel         = PTR_W'(i) - rp;
    assign slotLoad[i] = push && !flush && (wp == PTR_W'(i));
    assign slotKeep[i] = !flush && ({1'b0, rel} < count) && !(pop && (rp == PTR_W'(i)));

    frame_slot #(
      .DATA_W   (DATA_W),
      .REGADDR_W(REGADDR_W),
      .RSEL_W   (RSEL_W)
    ) uSlot (
      .clk     (clk),
      .reset   (reset),
      .load    (slotLoad[i]),
      .loadData(frame_in),
      .keep    (slotKeep[i]),
      .wbValid (wb_valid),
      .wbAddr  (wb_addr),
      .wbData  (wb_data),
      .frame   (slotData[i])
    );
  end

endmodule

// File: tb/tb_pipeline_frame_buffer.sv
// Directed bench for pipeline_frame_buffer: handshake, wrap, streaming, snoop, flush, reset.
module tb_pipeline_frame_buffer;
  import pipeline_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid, in_ready, out_valid, out_ready, flush, wb_valid;
  logic [FRAME_W-1:0] frame_in, frame_out;
  logic [REGADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]  wb_data;
  logic [1:0]         occupancy;
  frame_t             fo;

  int nChecks = 0;
  int nFails  = 0;

  assign fo = frame_t'(frame_out);

  pipeline_frame_buffer #(.DEPTH(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .frame_in (frame_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .frame_out(frame_out),
    .flush    (flush),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic frame_t mk(input logic [31:0] aOp, input logic [4:0] aL,
                                input logic [31:0] bOp, input logic [4:0] bL,
                                input logic [31:0] imm);
    frame_t f;
    f.aOperand        = aOp;
    f.aLoc            = aL;
    f.bOperand        = bOp;
    f.bLoc            = bL;
    f.immediateVal    = imm;
    f.immediateSelect = 1'b1;
    f.unsignedSelect  = 1'b0;
    f.subtractEnable  = 1'b1;
    f.resultSelect    = 3'b101;
    f.writeSelect     = aL + 5'd1;
    f.writeEnable     = 1'b1;
    return f;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  frame_t fA, fB, fC, fG;

  initial begin
    reset = 1'b1; in_valid = 0; out_ready = 0; flush = 0;
    wb_valid = 0; wb_addr = '0; wb_data = '0; frame_in = '0;
    #2;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_occupancy", 128'(occupancy), 128'd0);
    check("rst_frame_out", 128'(frame_out), 128'd0);
    check("rst_in_ready",  128'(in_ready),  128'd0);
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 128'(in_ready), 128'd1);

    // Single push then pop
    fA = mk(32'h11, 5'd3, 32'h22, 5'd4, 32'h0);
    frame_in = fA; in_valid = 1;
    tick();
    in_valid = 0;
    check("t1_out_valid", 128'(out_valid), 128'd1);
    check("t1_frame_out", 128'(frame_out), 128'(fA));
    check("t1_occupancy", 128'(occupancy), 128'd1);
    check("t1_pkg_aloc",  128'(getALoc(frame_out)), 128'd3);
    out_ready = 1;
    tick();
    out_ready = 0;
    check("t1_pop_occ",   128'(occupancy), 128'd0);
    check("t1_pop_valid", 128'(out_valid), 128'd0);

    // Fill to capacity; third push refused
    fA = mk(32'hA, 5'd1, 32'hB, 5'd2, 32'h1);
    fB = mk(32'hC, 5'd6, 32'hD, 5'd8, 32'h2);
    fC = mk(32'hE, 5'd9, 32'hF, 5'd10, 32'h3);
    frame_in = fA; in_valid = 1;
    tick();
    check("t2_ready_1", 128'(in_ready), 128'd1);
    frame_in = fB;
    tick();
    check("t2_ready_full", 128'(in_ready), 128'd0);
    check("t2_occ_full",   128'(occupancy), 128'd2);
    frame_in = fC;
    tick();
    in_valid = 0;
    check("t2_occ_refused", 128'(occupancy), 128'd2);
    check("t2_head_A",      128'(frame_out), 128'(fA));
    out_ready = 1;
    tick();
    out_ready = 0;
    check("t2_ready_after_pop", 128'(in_ready), 128'd1);
    check("t2_head_B",          128'(frame_out), 128'(fB));
    check("t2_occ_1",           128'(occupancy), 128'd1);
    out_ready = 1;
    tick();
    out_ready = 0;
    check("t2_empty", 128'(occupancy), 128'd0);
    for (int k = 0; k < 8; k++) begin
      frame_in = mk(32'h0, 5'd0, 32'h0, 5'd0, 32'h100 + k); in_valid = 1;
      tick();
      in_valid = 0;
      check("t2_wrap_head", 128'(fo.immediateVal), 128'(32'h100 + k));
      out_ready = 1;
      tick();
      out_ready = 0;
    end
    check("t2_wrap_empty", 128'(occupancy), 128'd0);

    // Streaming push+pop every cycle
    frame_in = mk(32'h0, 5'd0, 32'h0, 5'd0, 32'd0); in_valid = 1;
    tick();
    out_ready = 1;
    for (int k = 1; k <= 20; k++) begin
      frame_in = mk(32'h0, 5'd0, 32'h0, 5'd0, 32'(k));
      tick();
      check("t3_order", 128'(fo.immediateVal), 128'(k));
      check("t3_occ",   128'(occupancy), 128'd1);
    end
    in_valid = 0;
    tick();
    out_ready = 0;
    check("t3_drained", 128'(occupancy), 128'd0);

    // Snoop into held frames
    fA = mk(32'h1, 5'd5, 32'h2, 5'd5, 32'h0);
    fB = mk(32'h3, 5'd5, 32'h4, 5'd9, 32'h0);
    frame_in = fA; in_valid = 1;
    tick();
    frame_in = fB;
    tick();
    in_valid = 0;
    wb_valid = 1; wb_addr = 5'd5; wb_data = 32'hDEAD;
    tick();
    wb_valid = 0;
    check("t4_a_snoop", 128'(fo.aOperand), 128'h0000DEAD);
    check("t4_b_snoop", 128'(fo.bOperand), 128'h0000DEAD);
    out_ready = 1;
    tick();
    out_ready = 0;
    check("t4_second_a", 128'(fo.aOperand), 128'h0000DEAD);
    check("t4_second_b", 128'(fo.bOperand), 128'h4);
    out_ready = 1;
    tick();
    out_ready = 0;
    frame_in = mk(32'h55, 5'd0, 32'h66, 5'd0, 32'h0); in_valid = 1;
    tick();
    in_valid = 0;
    wb_valid = 1; wb_addr = 5'd0; wb_data = 32'hBEEF;
    tick();
    wb_valid = 0;
    check("t4_r0_a", 128'(fo.aOperand), 128'h55);
    check("t4_r0_b", 128'(fo.bOperand), 128'h66);
    out_ready = 1;
    tick();
    out_ready = 0;
    frame_in = mk(32'h77, 5'd7, 32'h88, 5'd2, 32'h0); in_valid = 1;
    wb_valid = 1; wb_addr = 5'd7; wb_data = 32'h1234;
    tick();
    in_valid = 0; wb_valid = 0;
    check("t4_push_snoop_a", 128'(fo.aOperand), 128'h1234);
    check("t4_push_snoop_b", 128'(fo.bOperand), 128'h88);
    out_ready = 1;
    tick();
    out_ready = 0;

    // Flush on a full buffer with push and pop requested
    in_valid = 1;
    frame_in = mk(32'h1, 5'd1, 32'h1, 5'd1, 32'hA1);
    tick();
    frame_in = mk(32'h2, 5'd2, 32'h2, 5'd2, 32'hA2);
    tick();
    check("t5_full", 128'(occupancy), 128'd2);
    frame_in = mk(32'h3, 5'd3, 32'h3, 5'd3, 32'hA3);
    out_ready = 1; flush = 1;
    tick();
    check("t5_flush_occ",   128'(occupancy), 128'd0);
    check("t5_flush_valid", 128'(out_valid), 128'd0);
    // Flush with an accepted push: the frame must still vanish
    flush = 0; out_ready = 0;
    frame_in = mk(32'h4, 5'd4, 32'h4, 5'd4, 32'hA4);
    tick();
    frame_in = mk(32'h5, 5'd5, 32'h5, 5'd5, 32'hA5);
    flush = 1;
    tick();
    flush = 0; in_valid = 0;
    check("t5_flush2_occ", 128'(occupancy), 128'd0);
    check("t5_flush2_rdy", 128'(in_ready),  128'd1);
    fG = mk(32'h99, 5'd11, 32'h98, 5'd12, 32'hCC);
    frame_in = fG; in_valid = 1;
    tick();
    in_valid = 0;
    check("t5_after_flush_head", 128'(frame_out), 128'(fG));
    check("t5_after_flush_occ",  128'(occupancy), 128'd1);

    // Asynchronous reset mid-stream
    frame_in = mk(32'h6, 5'd6, 32'h6, 5'd6, 32'hA6); in_valid = 1;
    tick();
    in_valid = 0;
    check("t6_held", 128'(occupancy), 128'd2);
    #2;
    reset = 1;
    #1;
    check("t6_rst_valid", 128'(out_valid), 128'd0);
    check("t6_rst_occ",   128'(occupancy), 128'd0);
    check("t6_rst_frame", 128'(frame_out), 128'd0);
    check("t6_rst_ready", 128'(in_ready),  128'd0);
    tick();
    reset = 0;
    tick();
    check("t6_rel_ready", 128'(in_ready),  128'd1);
    check("t6_rel_valid", 128'(out_valid), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
